// File: rtl/learn_costs_param_pkg.sv
// Shared types and default memory map for the learn-costs routing-table updater.
// State enumeration is shared by the top FSM and the sink copier.
package learn_costs_param_pkg;

  typedef enum logic [4:0] {
    StIdle, StRdNcnt, StRdScnt, StSrchAddr, StSrchCmp, StUpdBatt, StRdQ, StWrQ, StWrEps,
    StNewNid, StNewBatt, StNewQ, StNewClid, StWrNcnt, StSinkRd, StSinkWr, StSinkCnt, StDone
  } state_e;

  localparam int unsigned NcountAddrDef  = 32'h68A;
  localparam int unsigned ScountAddrDef  = 32'h688;
  localparam int unsigned EpsAddrDef     = 32'h004;
  localparam int unsigned KsinkBaseDef   = 32'h008;
  localparam int unsigned NidBaseDef     = 32'h048;
  localparam int unsigned ClidBaseDef    = 32'h0C8;
  localparam int unsigned BattBaseDef    = 32'h148;
  localparam int unsigned QvalBaseDef    = 32'h1C8;
  localparam int unsigned SidBaseDef     = 32'h248;
  localparam int unsigned SidcntBaseDef  = 32'h68E;

endpackage

// File: rtl/learn_costs_param_if.sv
// Shared single-port memory bus: combinational read data, one-cycle write strobe.
interface learn_costs_param_if #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] data_out;
    logic [WORD_WIDTH-1:0] data_in;

    modport master (output address, output wr_en, output data_out, input data_in);
    modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface

// File: rtl/lc_sink_copier.sv
// Copies the known-sink list into one neighbour's sink-ID row, then writes its count.
// Bus outputs are registered and idle at zero so the top can mux them in.
module lc_sink_copier
    import learn_costs_param_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned KSINK_BASE = KsinkBaseDef
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] sink_count,
    input  logic [WORD_WIDTH-1:0] row_base,
    input  logic [WORD_WIDTH-1:0] cnt_addr,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  done
);

    state_e                state;
    logic [WORD_WIDTH-1:0] k;
    logic [WORD_WIDTH-1:0] k_inc;

    assign k_inc = k + WORD_WIDTH'(1);

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state    <= StIdle;
            k        <= '0;
            address  <= '0;
            wr_en    <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        k <= '0;
                        if (sink_count == '0) begin
                            state    <= StSinkCnt;
                            wr_en    <= 1'b1;
                            address  <= ADDR_WIDTH'(cnt_addr);
                            data_out <= sink_count;
                        end else begin
                            state   <= StSinkRd;
                            address <= ADDR_WIDTH'(WORD_WIDTH'(KSINK_BASE));
                        end
                    end
                end
                StSinkRd: begin
                    state    <= StSinkWr;
                    wr_en    <= 1'b1;
                    address  <= ADDR_WIDTH'(row_base + (k << 1));
                    data_out <= data_in;
                end
                StSinkWr: begin
                    if (k_inc == sink_count) begin
                        state    <= StSinkCnt;
                        wr_en    <= 1'b1;
                        address  <= ADDR_WIDTH'(cnt_addr);
                        data_out <= sink_count;
                    end else begin
                        k       <= k_inc;
                        state   <= StSinkRd;
                        address <= ADDR_WIDTH'(WORD_WIDTH'(KSINK_BASE) + (k_inc << 1));
                    end
                end
                StSinkCnt: begin
                    state    <= StIdle;
                    done     <= 1'b1;
                    address  <= '0;
                    data_out <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/learn_costs_param.sv
// Updates the neighbour routing table in shared memory from one received packet:
// search by source ID, refresh or append the entry, then copy the known-sink list.
module learn_costs_param
    import learn_costs_param_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter int unsigned MAX_NEIGHBORS = 32,
    parameter int unsigned MAX_SINKS     = 8,
    parameter int unsigned NCOUNT_ADDR   = NcountAddrDef,
    parameter int unsigned SCOUNT_ADDR   = ScountAddrDef,
    parameter int unsigned EPS_ADDR      = EpsAddrDef,
    parameter int unsigned KSINK_BASE    = KsinkBaseDef,
    parameter int unsigned NID_BASE      = NidBaseDef,
    parameter int unsigned CLID_BASE     = ClidBaseDef,
    parameter int unsigned BATT_BASE     = BattBaseDef,
    parameter int unsigned QVAL_BASE     = QvalBaseDef,
    parameter int unsigned SID_BASE      = SidBaseDef,
    parameter int unsigned SIDCNT_BASE   = SidcntBaseDef
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] fsourceID,
    input  logic [WORD_WIDTH-1:0] fbatteryStat,
    input  logic [WORD_WIDTH-1:0] fValue,
    input  logic [WORD_WIDTH-1:0] fclusterID,
    input  logic [WORD_WIDTH-1:0] initial_epsilon,
    learn_costs_param_if.master   mem,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic                  hit
);

    localparam logic [WORD_WIDTH-1:0] MaxNbr    = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] MaxSnk    = WORD_WIDTH'(MAX_SINKS);
    localparam logic [WORD_WIDTH-1:0] RowStride = WORD_WIDTH'(2 * MAX_SINKS);

    state_e                state;
    logic [WORD_WIDTH-1:0] ncount, scount, n, rd_data, row_base, cnt_addr;
    logic [ADDR_WIDTH-1:0] addr_q, cp_addr;
    logic [WORD_WIDTH-1:0] data_q, cp_data;
    logic                  wr_en_q, cp_wr_en, cp_start, cp_done, cp_sel;

    // Table addresses are formed at word width, then truncated to the bus.
    function automatic logic [ADDR_WIDTH-1:0] tbl(input int unsigned base,
                                                  input logic [WORD_WIDTH-1:0] idx);
        logic [WORD_WIDTH-1:0] a;
        a = WORD_WIDTH'(base) + (idx << 1);
        return a[ADDR_WIDTH-1:0];
    endfunction

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state    <= StIdle;
            ncount   <= '0;
            scount   <= '0;
            n        <= '0;
            rd_data  <= '0;
            row_base <= '0;
            cnt_addr <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
            cp_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            full     <= 1'b0;
            hit      <= 1'b0;
        end else begin
            wr_en_q  <= 1'b0;
            done     <= 1'b0;
            cp_start <= 1'b0;
            case (state)
                StIdle: if (en) begin
                    state  <= StRdNcnt;
                    busy   <= 1'b1;
                    hit    <= 1'b0;
                    full   <= 1'b0;
                    addr_q <= ADDR_WIDTH'(WORD_WIDTH'(NCOUNT_ADDR));
                end
                StRdNcnt: begin
                    ncount <= mem.data_in;
                    addr_q <= ADDR_WIDTH'(WORD_WIDTH'(SCOUNT_ADDR));
                    state  <= StRdScnt;
                end
                StRdScnt: begin
                    scount <= (mem.data_in > MaxSnk) ? MaxSnk : mem.data_in;
                    n      <= '0;
                    addr_q <= tbl(NID_BASE, '0);
                    state  <= StSrchAddr;
                end
                StSrchAddr: begin
                    if (n != ncount) begin
                        rd_data <= mem.data_in;
                        state   <= StSrchCmp;
                    end else if (ncount >= MaxNbr) begin
                        full   <= 1'b1;
                        done   <= 1'b1;
                        addr_q <= '0;
                        state  <= StDone;
                    end else begin
                        // n already equals ncount, so the new entry reuses it.
                        state   <= StNewNid;
                        wr_en_q <= 1'b1;
                        addr_q  <= tbl(NID_BASE, ncount);
                        data_q  <= fsourceID;
                    end
                end
                StSrchCmp: begin
                    if (rd_data == fsourceID) begin
                        hit     <= 1'b1;
                        state   <= StUpdBatt;
                        wr_en_q <= 1'b1;
                        addr_q  <= tbl(BATT_BASE, n);
                        data_q  <= fbatteryStat;
                    end else begin
                        n      <= n + WORD_WIDTH'(1);
                        addr_q <= tbl(NID_BASE, n + WORD_WIDTH'(1));
                        state  <= StSrchAddr;
                    end
                end
                StUpdBatt: begin
                    addr_q <= tbl(QVAL_BASE, n);
                    state  <= StRdQ;
                end
                StRdQ: begin
                    rd_data <= mem.data_in;
                    wr_en_q <= 1'b1;
                    data_q  <= fValue;
                    state   <= StWrQ;
                end
                StWrQ: begin
                    if (rd_data < fValue) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= ADDR_WIDTH'(WORD_WIDTH'(EPS_ADDR));
                        data_q  <= initial_epsilon;
                        state   <= StWrEps;
                    end else begin
                        addr_q <= '0;
                        state  <= StSinkRd;
                    end
                end
                StWrEps: begin
                    addr_q <= '0;
                    state  <= StSinkRd;
                end
                StNewNid: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= tbl(BATT_BASE, ncount);
                    data_q  <= fbatteryStat;
                    state   <= StNewBatt;
                end
                StNewBatt: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= tbl(QVAL_BASE, ncount);
                    data_q  <= fValue;
                    state   <= StNewQ;
                end
                StNewQ: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= tbl(CLID_BASE, ncount);
                    data_q  <= fclusterID;
                    state   <= StNewClid;
                end
                StNewClid: begin
                    wr_en_q <= 1'b1;
                    addr_q  <= ADDR_WIDTH'(WORD_WIDTH'(NCOUNT_ADDR));
                    data_q  <= ncount + WORD_WIDTH'(1);
                    state   <= StWrNcnt;
                end
                StWrNcnt: begin
                    addr_q <= '0;
                    state  <= StSinkRd;
                end
                // SinkRd launches the copier; SinkWr waits while it owns the bus.
                StSinkRd: begin
                    row_base <= WORD_WIDTH'(SID_BASE) + n * RowStride;
                    cnt_addr <= WORD_WIDTH'(SIDCNT_BASE) + (n << 1);
                    cp_start <= 1'b1;
                    state    <= StSinkWr;
                end
                StSinkWr: if (cp_done) begin
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign cp_sel       = (state == StSinkRd) || (state == StSinkWr);
    assign mem.address  = cp_sel ? cp_addr : addr_q;
    assign mem.wr_en    = cp_sel ? cp_wr_en : wr_en_q;
    assign mem.data_out = cp_sel ? cp_data : data_q;

    lc_sink_copier #(
        .WORD_WIDTH (WORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .KSINK_BASE (KSINK_BASE)
    ) u_copier (
        .clock      (clock),
        .nrst       (nrst),
        .start      (cp_start),
        .sink_count (scount),
        .row_base   (row_base),
        .cnt_addr   (cnt_addr),
        .data_in    (mem.data_in),
        .address    (cp_addr),
        .wr_en      (cp_wr_en),
        .data_out   (cp_data),
        .done       (cp_done)
    );

endmodule

// File: tb/tb_learn_costs_param.sv
// Scoreboard bench: directed runs push expected writes and completions; a negedge
// monitor pops and compares each wr_en and done seen on the DUT.
module tb_learn_costs_param;
    import learn_costs_param_pkg::*;

    typedef struct {
        bit          is_done;
        logic [10:0] addr;
        logic [15:0] data;
        bit          hit;
        bit          full;
    } exp_t;

    logic        clock, nrst, en;
    logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon;
    logic        busy, done, full, hit;
    logic [15:0] mem [0:1023];
    logic        poke_we;
    logic [10:0] poke_addr;
    logic [15:0] poke_data;
    exp_t        exp_q[$];
    int          checks, errors, done_cnt;

    learn_costs_param_if #(.WORD_WIDTH(16), .ADDR_WIDTH(11)) mem_if ();

    learn_costs_param dut (
        .clock           (clock),
        .nrst            (nrst),
        .en              (en),
        .fsourceID       (fsourceID),
        .fbatteryStat    (fbatteryStat),
        .fValue          (fValue),
        .fclusterID      (fclusterID),
        .initial_epsilon (initial_epsilon),
        .mem             (mem_if),
        .busy            (busy),
        .done            (done),
        .full            (full),
        .hit             (hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_if.data_in = mem[mem_if.address[10:1]];

    always @(posedge clock) begin
        if (mem_if.wr_en) mem[mem_if.address[10:1]] <= mem_if.data_out;
        else if (poke_we) mem[poke_addr[10:1]] <= poke_data;
    end

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        if (nrst && mem_if.wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%h:%h required=none",
                         mem_if.address, mem_if.data_out);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done || e.addr !== mem_if.address || e.data !== mem_if.data_out) begin
                    errors++;
                    $display("FAIL write actual=%h:%h required=%h:%h done_expected=%0d",
                             mem_if.address, mem_if.data_out, e.addr, e.data, e.is_done);
                end
            end
        end
        if (nrst && done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=hit%0d/full%0d required=none", hit, full);
            end else begin
                e = exp_q.pop_front();
                if (!e.is_done || e.hit !== hit || e.full !== full) begin
                    errors++;
                    $display("FAIL done actual=hit%0d/full%0d required=hit%0d/full%0d done=%0d",
                             hit, full, e.hit, e.full, e.is_done);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [15:0] d);
        poke_we   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clock);
        #1 poke_we = 1'b0;
    endtask

    function automatic void exp_wr(input logic [10:0] a, input logic [15:0] d);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d; e.hit = 1'b0; e.full = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_done(input bit h, input bit f);
        exp_t e;
        e.is_done = 1'b1; e.addr = '0; e.data = '0; e.hit = h; e.full = f;
        exp_q.push_back(e);
    endfunction

    task automatic set_pkt(input logic [15:0] sid, input logic [15:0] batt,
                           input logic [15:0] val, input logic [15:0] clid);
        fsourceID = sid; fbatteryStat = batt; fValue = val; fclusterID = clid;
    endtask

    task automatic pulse_en();
        @(negedge clock);
        en = 1'b1;
        @(negedge clock);
        en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  start_cnt;
        bit  seen;
        start_cnt = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            #2;
            if (done_cnt != start_cnt) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        bit found;
        nrst = 1'b0; en = 1'b0; poke_we = 1'b0; poke_addr = '0; poke_data = '0;
        checks = 0; errors = 0; done_cnt = 0;
        set_pkt(16'h0, 16'h0, 16'h0, 16'h0);
        initial_epsilon = 16'h0099;
        #12;
        check("rst_address", mem_if.address, 0);
        check("rst_wr_en", mem_if.wr_en, 0);
        check("rst_data_out", mem_if.data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full_hit", {full, hit}, 0);
        @(negedge clock);
        nrst = 1'b1;

        // Empty table: append ID 5 with two sinks
        poke(11'h68A, 16'd0); poke(11'h688, 16'd2);
        poke(11'h008, 16'h00A1); poke(11'h00A, 16'h00B2);
        set_pkt(16'd5, 16'h0064, 16'h0014, 16'h0003);
        exp_wr(11'h048, 16'd5); exp_wr(11'h148, 16'h0064); exp_wr(11'h1C8, 16'h0014);
        exp_wr(11'h0C8, 16'h0003); exp_wr(11'h68A, 16'd1);
        exp_wr(11'h248, 16'h00A1); exp_wr(11'h24A, 16'h00B2); exp_wr(11'h68E, 16'd2);
        exp_done(1'b0, 1'b0);
        pulse_en();
        check("busy_running", busy, 1);
        wait_done("append");

        // Hit on entry 3, old Q 10 < 20: epsilon reload
        poke(11'h68A, 16'd4); poke(11'h688, 16'd1);
        poke(11'h048, 16'd1); poke(11'h04A, 16'd2); poke(11'h04C, 16'd3); poke(11'h04E, 16'd7);
        poke(11'h1CE, 16'd10); poke(11'h008, 16'h00C3);
        set_pkt(16'd7, 16'h0055, 16'd20, 16'h0009);
        exp_wr(11'h14E, 16'h0055); exp_wr(11'h1CE, 16'd20); exp_wr(11'h004, 16'h0099);
        exp_wr(11'h278, 16'h00C3); exp_wr(11'h694, 16'd1);
        exp_done(1'b1, 1'b0);
        pulse_en();
        wait_done("hit_eps");
        check("ncount_kept", mem[11'h68A >> 1], 4);

        // Hit with old Q 30 >= 20: no epsilon; zero known sinks
        poke(11'h1CE, 16'd30); poke(11'h688, 16'd0);
        exp_wr(11'h14E, 16'h0055); exp_wr(11'h1CE, 16'd20); exp_wr(11'h694, 16'd0);
        exp_done(1'b1, 1'b0);
        pulse_en();
        wait_done("hit_noeps");

        // Full table, unknown ID
        poke(11'h68A, 16'd32); poke(11'h688, 16'd2);
        for (int i = 0; i < 32; i++) poke(11'(32'h048 + 2 * i), 16'(100 + i));
        set_pkt(16'h03E7, 16'h0001, 16'h0002, 16'h0003);
        exp_done(1'b0, 1'b1);
        pulse_en();
        wait_done("full");

        // Sink count above capacity is clamped
        poke(11'h68A, 16'd1); poke(11'h688, 16'd11);
        poke(11'h048, 16'h0011); poke(11'h1C8, 16'd50);
        for (int k = 0; k < 11; k++) poke(11'(32'h008 + 2 * k), 16'(32'h100 + k));
        set_pkt(16'h0011, 16'h0077, 16'd20, 16'h0004);
        exp_wr(11'h148, 16'h0077); exp_wr(11'h1C8, 16'd20);
        for (int k = 0; k < 8; k++) exp_wr(11'(32'h248 + 2 * k), 16'(32'h100 + k));
        exp_wr(11'h68E, 16'd8);
        exp_done(1'b1, 1'b0);
        pulse_en();
        wait_done("clamp");

        // Reset in the middle of the sink copy
        poke(11'h688, 16'd3); poke(11'h690, 16'hDEAD); poke(11'h25C, 16'hBEEF);
        set_pkt(16'h0022, 16'h0033, 16'h0044, 16'h0005);
        exp_wr(11'h04A, 16'h0022); exp_wr(11'h14A, 16'h0033); exp_wr(11'h1CA, 16'h0044);
        exp_wr(11'h0CA, 16'h0005); exp_wr(11'h68A, 16'd2);
        exp_wr(11'h258, 16'h0100); exp_wr(11'h25A, 16'h0101);
        pulse_en();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            #1;
            if (mem_if.wr_en && mem_if.address == 11'h25A) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached", found, 1);
        nrst = 1'b0;
        #1;
        check("abort_wr_en", mem_if.wr_en, 0);
        check("abort_busy", busy, 0);
        check("abort_address", mem_if.address, 0);
        repeat (3) @(negedge clock);
        nrst = 1'b1;
        check("abort_drained", exp_q.size(), 0);
        check("abort_no_cnt", mem[11'h690 >> 1], 16'hDEAD);
        check("abort_no_sink2", mem[11'h25C >> 1], 16'hBEEF);

        // Clean rerun finds the appended entry 1
        set_pkt(16'h0022, 16'h0033, 16'h0050, 16'h0005);
        exp_wr(11'h14A, 16'h0033); exp_wr(11'h1CA, 16'h0050); exp_wr(11'h004, 16'h0099);
        exp_wr(11'h258, 16'h0100); exp_wr(11'h25A, 16'h0101); exp_wr(11'h25C, 16'h0102);
        exp_wr(11'h690, 16'd3);
        exp_done(1'b1, 1'b0);
        pulse_en();
        wait_done("rerun");
        repeat (2) @(negedge clock);
        check("idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
